// File: rtl/self_test_pkg.sv
// Shared types for the self_test sequencer: FSM states, the default word width
// and the status bit layout that the host-side register block also decodes.
package self_test_pkg;

  localparam int DEFAULT_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    REL,
    WAIT,
    CHECK,
    FLAYER,
    FIN
  } state_e;

  // Bit order here is the host status register layout, LSB first = busy.
  typedef struct packed {
    logic timeoutFlag;
    logic pass;
    logic done;
    logic busy;
  } status_t;

  function automatic int maxOf3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/st_vec_ram.sv
// Vector slot storage: each entry packs {expected result, test word}.
// Written synchronously from the config side, read asynchronously by the sequencer.
module st_vec_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [2*DW-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [2*DW-1:0] rdata_o
);

  logic [2*DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/self_test_seq.sv
// On-chip sequencer that steps the self_test datapath through the programmed
// vectors, scores each result, then runs the final-layer window.
module self_test_seq
  import self_test_pkg::*;
#(
  parameter int DW        = DEFAULT_DW,
  parameter int VEC_DEPTH = 8,
  parameter int RST_CYC   = 3,
  parameter int TIMEOUT   = 64,
  parameter int FL_CYC    = 50,
  localparam int AW       = $clog2(VEC_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [DW-1:0] cfg_data_i,
  input  logic [DW-1:0] cfg_exp_i,
  input  logic          start_i,
  input  logic [AW:0]   num_vec_i,
  output logic          st_rst_n_o,
  output logic          st_f_layer_o,
  output logic [DW-1:0] st_data_in_o,
  input  logic          st_sort_finish_i,
  input  logic [DW-1:0] st_data_out_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [AW:0]   fail_cnt_o,
  output logic [AW-1:0] first_fail_o,
  output logic          timeout_flag_o
);

  localparam int CNT_MAX = maxOf3(RST_CYC, TIMEOUT, FL_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e          state_q;
  status_t         status_q;
  logic [AW-1:0]   idx_q;
  logic [AW:0]     numVec_q;
  logic [AW:0]     numVec_d;
  logic [CW-1:0]   cnt_q;
  logic            miss_q;
  logic            tmo_q;
  logic            stRstN_q;
  logic            stFLayer_q;
  logic [DW-1:0]   stDataIn_q;
  logic [AW:0]     failCnt_q;
  logic [AW-1:0]   firstFail_q;
  logic [AW-1:0]   rdAddr_d;
  logic [2*DW-1:0] ramRd;

  st_vec_ram #(
    .DW   (DW),
    .DEPTH(VEC_DEPTH),
    .AW   (AW)
  ) u_vec_ram (
    .clk    (clk),
    .we_i   (cfg_we_i & ~status_q.busy),
    .waddr_i(cfg_addr_i),
    .wdata_i({cfg_exp_i, cfg_data_i}),
    .raddr_i(rdAddr_d),
    .rdata_o(ramRd)
  );

  assign numVec_d = (num_vec_i > (AW+1)'(VEC_DEPTH)) ? (AW+1)'(VEC_DEPTH) : num_vec_i;

  // IDLE and CHECK look one slot ahead so the next word is ready as RST is entered.
  always_comb begin
    rdAddr_d = idx_q;
    if (state_q == IDLE) begin
      rdAddr_d = '0;
    end else if (state_q == CHECK) begin
      rdAddr_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      status_q    <= '0;
      idx_q       <= '0;
      numVec_q    <= '0;
      cnt_q       <= '0;
      miss_q      <= 1'b0;
      tmo_q       <= 1'b0;
      stRstN_q    <= 1'b0;
      stFLayer_q  <= 1'b0;
      stDataIn_q  <= '0;
      failCnt_q   <= '0;
      firstFail_q <= '0;
    end else begin
      status_q.done <= 1'b0;
      case (state_q)
        IDLE: begin
          stRstN_q <= 1'b1;
          if (start_i) begin
            numVec_q             <= numVec_d;
            failCnt_q            <= '0;
            firstFail_q          <= '0;
            status_q.timeoutFlag <= 1'b0;
            status_q.pass        <= 1'b0;
            status_q.busy        <= 1'b1;
            idx_q                <= '0;
            cnt_q                <= '0;
            if (numVec_d != '0) begin
              state_q    <= RST;
              stRstN_q   <= 1'b0;
              stDataIn_q <= ramRd[DW-1:0];
            end else begin
              state_q    <= FLAYER;
              stFLayer_q <= 1'b1;
            end
          end
        end
        RST: begin
          if (cnt_q == CW'(RST_CYC - 1)) begin
            state_q  <= REL;
            stRstN_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REL: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: begin
          if (st_sort_finish_i) begin
            miss_q  <= (st_data_out_i != ramRd[2*DW-1:DW]);
            tmo_q   <= 1'b0;
            state_q <= CHECK;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            status_q.timeoutFlag <= 1'b1;
            miss_q               <= 1'b0;
            tmo_q                <= 1'b1;
            state_q              <= CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (miss_q || tmo_q) begin
            if (failCnt_q != (AW+1)'(VEC_DEPTH)) begin
              failCnt_q <= failCnt_q + 1'b1;
            end
            if (failCnt_q == '0) begin
              firstFail_q <= idx_q;
            end
          end
          cnt_q <= '0;
          if ({1'b0, idx_q} == numVec_q - 1'b1) begin
            state_q    <= FLAYER;
            stFLayer_q <= 1'b1;
          end else begin
            idx_q      <= idx_q + 1'b1;
            state_q    <= RST;
            stRstN_q   <= 1'b0;
            stDataIn_q <= ramRd[DW-1:0];
          end
        end
        FLAYER: begin
          if (cnt_q == CW'(FL_CYC - 1)) begin
            stFLayer_q    <= 1'b0;
            state_q       <= FIN;
            status_q.done <= 1'b1;
            status_q.busy <= 1'b0;
            status_q.pass <= (failCnt_q == '0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign st_rst_n_o     = stRstN_q;
  assign st_f_layer_o   = stFLayer_q;
  assign st_data_in_o   = stDataIn_q;
  assign busy_o         = status_q.busy;
  assign done_o         = status_q.done;
  assign pass_o         = status_q.pass;
  assign fail_cnt_o     = failCnt_q;
  assign first_fail_o   = firstFail_q;
  assign timeout_flag_o = status_q.timeoutFlag;

endmodule

// File: tb/tb_self_test_seq.sv
// Bench for self_test_seq: a behavioural stand-in for the self_test datapath
// (half-word swap after a fixed latency) plus directed runs with hand-computed results.
module tb_self_test_seq;

  localparam int MODEL_LAT = 3;
  localparam logic [31:0] W0 = 32'hEAB6BAE1;
  localparam logic [31:0] W1 = 32'hEA08AEAF;
  localparam logic [31:0] W2 = 32'hEA3A0AEF;
  localparam logic [31:0] E0 = 32'hBAE1EAB6;
  localparam logic [31:0] E1 = 32'hAEAFEA08;
  localparam logic [31:0] E2 = 32'h0AEFEA3A;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfgWe;
  logic [2:0]  cfgAddr;
  logic [31:0] cfgData;
  logic [31:0] cfgExp;
  logic        start;
  logic [3:0]  numVec;
  logic        stRstN;
  logic        stFLayer;
  logic [31:0] stDataIn;
  logic        sortFinish;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  failCnt;
  logic [2:0]  firstFail;
  logic        timeoutFlag;

  logic        stuck, hang0, invert;
  logic [7:0]  modelCnt;
  logic        clrMon;
  int          busyCyc, lowCyc, flCyc, doneCnt, rstPulses;
  logic        prevRstN;
  int          checkCnt = 0;
  int          passCnt = 0;

  always #5 clk = ~clk;

  self_test_seq dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we_i        (cfgWe),
    .cfg_addr_i      (cfgAddr),
    .cfg_data_i      (cfgData),
    .cfg_exp_i       (cfgExp),
    .start_i         (start),
    .num_vec_i       (numVec),
    .st_rst_n_o      (stRstN),
    .st_f_layer_o    (stFLayer),
    .st_data_in_o    (stDataIn),
    .st_sort_finish_i(sortFinish),
    .st_data_out_i   (dataOut),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .fail_cnt_o      (failCnt),
    .first_fail_o    (firstFail),
    .timeout_flag_o  (timeoutFlag)
  );

  function automatic logic [31:0] swapHalves(input logic [31:0] w);
    return {w[15:0], w[31:16]};
  endfunction

  // Datapath stand-in: finishes MODEL_LAT cycles after reset release.
  always @(posedge clk) begin
    if (!stRstN) modelCnt <= 8'd0;
    else if (modelCnt != 8'hFF) modelCnt <= modelCnt + 8'd1;
  end

  assign sortFinish = stuck || ((modelCnt >= MODEL_LAT) && !(hang0 && stDataIn == W0));
  assign dataOut    = invert ? ~swapHalves(stDataIn) : swapHalves(stDataIn);

  always @(negedge clk) begin
    if (clrMon) begin
      busyCyc   <= 0;
      lowCyc    <= 0;
      flCyc     <= 0;
      doneCnt   <= 0;
      rstPulses <= 0;
    end else begin
      if (busy) busyCyc <= busyCyc + 1;
      if (busy && !stRstN) lowCyc <= lowCyc + 1;
      if (busy && !stRstN && prevRstN) rstPulses <= rstPulses + 1;
      if (stFLayer) flCyc <= flCyc + 1;
      if (done) doneCnt <= doneCnt + 1;
    end
    prevRstN <= stRstN;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic writeSlot(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
    @(negedge clk);
    cfgWe = 1'b1; cfgAddr = a; cfgData = d; cfgExp = e;
    @(negedge clk);
    cfgWe = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] n);
    @(posedge clk);
    clrMon = 1'b1;
    @(negedge clk);
    numVec = n;
    start  = 1'b1;
    @(posedge clk);
    clrMon = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, seen, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cfgWe = 1'b0; cfgAddr = '0; cfgData = '0; cfgExp = '0;
    start = 1'b0; numVec = '0; stuck = 1'b0; hang0 = 1'b0; invert = 1'b0; clrMon = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_st_rst_n", stRstN, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_fail_cnt", failCnt, 0);
    checkOutput("rst_first_fail", firstFail, 0);
    checkOutput("rst_timeout", timeoutFlag, 0);
    checkOutput("rst_f_layer", stFLayer, 0);
    checkOutput("rst_data_in", stDataIn, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_st_rst_n", stRstN, 1);

    writeSlot(3'd0, W0, E0);
    writeSlot(3'd1, W1, E1);
    writeSlot(3'd2, W2, E2);
    for (int i = 3; i < 8; i++) writeSlot(3'(i), 32'h1234_0000 + i, swapHalves(32'h1234_0000 + i));

    // 3 clean vectors: each 3 RST + 1 REL + 3 WAIT + 1 CHECK = 8, then 50 FLAYER
    applyStimulus(4'd3);
    waitDone("clean", 400);
    checkOutput("clean_done_cnt", doneCnt, 1);
    checkOutput("clean_pass", pass, 1);
    checkOutput("clean_fail_cnt", failCnt, 0);
    checkOutput("clean_timeout", timeoutFlag, 0);
    checkOutput("clean_low_cyc", lowCyc, 9);
    checkOutput("clean_rst_pulses", rstPulses, 3);
    checkOutput("clean_fl_cyc", flCyc, 50);
    checkOutput("clean_busy_cyc", busyCyc, 74);
    checkOutput("clean_data_in_hold", stDataIn, W2);
    checkOutput("clean_busy_after", busy, 0);

    writeSlot(3'd1, W1, E1 ^ 32'd1);
    applyStimulus(4'd3);
    waitDone("bad1", 400);
    checkOutput("bad1_pass", pass, 0);
    checkOutput("bad1_fail_cnt", failCnt, 1);
    checkOutput("bad1_first_fail", firstFail, 1);
    checkOutput("bad1_timeout", timeoutFlag, 0);
    writeSlot(3'd1, W1, E1);

    // vector 0 hangs: 3 + 1 + 64 + 1 = 69, then 8 + 8 + 50
    hang0 = 1'b1;
    applyStimulus(4'd3);
    waitDone("tmo", 400);
    hang0 = 1'b0;
    checkOutput("tmo_busy_cyc", busyCyc, 135);
    checkOutput("tmo_flag", timeoutFlag, 1);
    checkOutput("tmo_fail_cnt", failCnt, 1);
    checkOutput("tmo_first_fail", firstFail, 0);
    checkOutput("tmo_rst_pulses", rstPulses, 3);
    checkOutput("tmo_pass", pass, 0);

    applyStimulus(4'd0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    writeSlot(3'd0, 32'hDEADBEEF, 32'h0);
    start = 1'b0;
    waitDone("zero", 400);
    checkOutput("zero_busy_cyc", busyCyc, 50);
    checkOutput("zero_fl_cyc", flCyc, 50);
    checkOutput("zero_rst_pulses", rstPulses, 0);
    checkOutput("zero_low_cyc", lowCyc, 0);
    checkOutput("zero_pass", pass, 1);
    checkOutput("zero_done_cnt", doneCnt, 1);

    applyStimulus(4'd3);
    waitDone("ram_kept", 400);
    checkOutput("ram_kept_pass", pass, 1);
    checkOutput("ram_kept_busy_cyc", busyCyc, 74);

    // finish stuck high: each vector 3 + 1 + 1 + 1 = 6; num_vec 15 clamps to 8
    stuck = 1'b1; invert = 1'b1;
    applyStimulus(4'd15);
    waitDone("sat", 600);
    checkOutput("sat_busy_cyc", busyCyc, 98);
    checkOutput("sat_fail_cnt", failCnt, 8);
    checkOutput("sat_first_fail", firstFail, 0);
    checkOutput("sat_rst_pulses", rstPulses, 8);
    checkOutput("sat_pass", pass, 0);
    invert = 1'b0;
    applyStimulus(4'd8);
    waitDone("stuck", 600);
    checkOutput("stuck_pass", pass, 1);
    checkOutput("stuck_busy_cyc", busyCyc, 98);
    stuck = 1'b0;

    // busy cycle 22 is the second WAIT cycle of vector 2
    applyStimulus(4'd3);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_st_rst_n", stRstN, 0);
    checkOutput("midrst_f_layer", stFLayer, 0);
    checkOutput("midrst_data_in", stDataIn, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midrst_no_done", doneCnt, 0);
    checkOutput("midrst_st_rst_n_rel", stRstN, 1);
    applyStimulus(4'd3);
    waitDone("rerun", 400);
    checkOutput("rerun_pass", pass, 1);
    checkOutput("rerun_fail_cnt", failCnt, 0);
    checkOutput("rerun_busy_cyc", busyCyc, 74);
    checkOutput("rerun_rst_pulses", rstPulses, 3);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
